// File: rtl/serial_word_collector.sv
// Collects an LSB-first serial bit stream into WIDTH-bit words behind a single-entry valid/ready register.
// Optional SERIAL_WORD_COLLECTOR_PARITY_EN adds a registered word_parity output.
module serial_word_collector #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             frame_start,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             overflow,
   input  logic             clr_overflow
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
   ,
   output logic             word_parity
`endif
);

   // Only the upper WIDTH-1 bits of the shift register are ever observed:
   // bit 0 is always shifted out before a word completes.
   logic [WIDTH-2:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-2:0] shift_base;
   logic [CNT_W-1:0] cnt_base;
   logic [WIDTH-1:0] shifted_word;
   logic             complete;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
   logic             parity_q, parity_d;
`endif

   // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
   always_comb begin
      shift_base   = frame_start ? '0 : shift_q;
      cnt_base     = frame_start ? '0 : cnt_q;
      shifted_word = {bit_in, shift_base};
      complete     = bit_valid && !frame_start && (cnt_q == CNT_W'(WIDTH - 1));

      shift_d = shift_base;
      cnt_d   = cnt_base;
      word_d  = word_q;
      valid_d = valid_q;
      ovf_d   = clr_overflow ? 1'b0 : ovf_q;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      parity_d = parity_q;
`endif

      if (bit_valid) begin
         shift_d = shifted_word[WIDTH-1:1];
         cnt_d   = complete ? '0 : cnt_base + CNT_W'(1);
      end

      if (complete) begin
         if (!valid_q || word_ready) begin
            word_d  = shifted_word;
            valid_d = 1'b1;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
            parity_d = ^shifted_word;
`endif
         end else begin
            // Source cannot stall: the new word is lost, the held word survives.
            ovf_d = 1'b1;
         end
      end else if (valid_q && word_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         shift_q <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
   always_ff @(posedge clk or posedge areset) begin
      if (areset) parity_q <= 1'b0;
      else        parity_q <= parity_d;
   end

   assign word_parity = parity_q;
`endif

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: directed scenarios plus a randomized run
// compared against a bit-list reference model.
module tb_serial_word_collector;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             areset = 1'b0;
   logic             frame_start = 1'b0;
   logic             bit_valid = 1'b0;
   logic             bit_in = 1'b0;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready = 1'b0;
   logic             overflow;
   logic             clr_overflow = 1'b0;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
   logic             word_parity;
`endif

   int errors = 0;
   int checks = 0;

   serial_word_collector #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .areset       (areset),
      .frame_start  (frame_start),
      .bit_valid    (bit_valid),
      .bit_in       (bit_in),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      ,
      .word_parity  (word_parity)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: bits of the current frame in arrival order, plus the output register contents.
   logic             m_bits[$];
   logic [WIDTH-1:0] m_word;
   logic             m_valid;
   logic             m_ovf;
   logic             m_par;

   function automatic void m_reset();
      m_bits.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_par   = 1'b0;
   endfunction

   function automatic void m_edge();
      logic [WIDTH-1:0] w;
      bit done;
      w    = '0;
      done = 0;
      if (frame_start) m_bits.delete();
      if (bit_valid) begin
         m_bits.push_back(bit_in);
         if (m_bits.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
            m_bits.delete();
            done = 1;
         end
      end
      if (clr_overflow) m_ovf = 1'b0;
      if (done) begin
         if (!m_valid || word_ready) begin
            m_word  = w;
            m_valid = 1'b1;
            m_par   = ($countones(w) % 2) == 1;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (m_valid && word_ready) begin
         m_valid = 1'b0;
      end
   endfunction

   // Advance one clock, update the model with the inputs seen at that edge, sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      if (areset) m_reset();
      else        m_edge();
      #1;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w);
      logic [WIDTH-1:0] tmp;
      tmp = w;
      for (int i = 0; i < WIDTH; i++) begin
         bit_valid = 1'b1;
         bit_in    = tmp[i];
         tick();
      end
   endtask

   task automatic test_reset();
      areset = 1'b1;
      #2;
      checks++;
      if (word_out !== '0 || word_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: word_out=%h valid=%b ovf=%b, expected 00/0/0", word_out, word_valid, overflow);
      end
      tick();
      tick();
      areset = 1'b0;
      m_reset();
      tick();
      checks++;
      if (word_valid !== 1'b0 || word_out !== '0) begin
         errors++;
         $display("FAIL reset_release: word_out=%h valid=%b, expected 00/0", word_out, word_valid);
      end
   endtask

   task automatic test_single_word();
      word_ready = 1'b1;
      send_word(8'hF4);
      bit_valid = 1'b0;
      checks++;
      if (word_out !== 8'hF4 || word_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_word: word_out=%h valid=%b, expected f4/1", word_out, word_valid);
      end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      checks++;
      if (word_parity !== 1'b1) begin
         errors++;
         $display("FAIL parity_f4: got %b expected 1", word_parity);
      end
`endif
      tick();
      checks++;
      if (word_valid !== 1'b0 || word_out !== 8'hF4) begin
         errors++;
         $display("FAIL single_word_consumed: word_out=%h valid=%b, expected f4/0", word_out, word_valid);
      end
   endtask

   task automatic test_back_to_back();
      word_ready = 1'b0;
      send_word(8'hF4);
      checks++;
      if (word_out !== 8'hF4 || word_valid !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: word_out=%h valid=%b ovf=%b, expected f4/1/0", word_out, word_valid, overflow);
      end
      send_word(8'h01);
      bit_valid = 1'b0;
      checks++;
      if (word_out !== 8'hF4 || word_valid !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drop: word_out=%h valid=%b ovf=%b, expected f4/1/1", word_out, word_valid, overflow);
      end
      tick();
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%b expected 1", overflow);
      end
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      checks++;
      if (overflow !== 1'b0 || word_out !== 8'hF4 || word_valid !== 1'b1) begin
         errors++;
         $display("FAIL clr_overflow: ovf=%b word_out=%h valid=%b, expected 0/f4/1", overflow, word_out, word_valid);
      end
   endtask

   task automatic test_simultaneous();
      logic [WIDTH-1:0] w;
      w = 8'h3C;
      word_ready = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         bit_valid  = 1'b1;
         bit_in     = w[i];
         word_ready = (i == WIDTH - 1);
         tick();
      end
      bit_valid  = 1'b0;
      word_ready = 1'b0;
      checks++;
      if (word_out !== 8'h3C || word_valid !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL simultaneous: word_out=%h valid=%b ovf=%b, expected 3c/1/0", word_out, word_valid, overflow);
      end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      checks++;
      if (word_parity !== 1'b0) begin
         errors++;
         $display("FAIL parity_3c: got %b expected 0", word_parity);
      end
`endif
   endtask

   task automatic test_frame_restart();
      bit seen_valid;
      seen_valid = 0;
      word_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1'b1;
         bit_in    = 1'b1;
         tick();
      end
      frame_start = 1'b1;
      bit_valid   = 1'b1;
      bit_in      = 1'b1;
      tick();
      frame_start = 1'b0;
      if (word_valid) seen_valid = 1;
      for (int i = 0; i < WIDTH - 1; i++) begin
         bit_in = 1'b0;
         tick();
         if (i < WIDTH - 2 && word_valid) seen_valid = 1;
      end
      bit_valid = 1'b0;
      checks++;
      if (seen_valid) begin
         errors++;
         $display("FAIL restart_partial: word_valid rose before the restarted frame completed, expected it to stay 0");
      end
      checks++;
      if (word_out !== 8'h01 || word_valid !== 1'b1) begin
         errors++;
         $display("FAIL frame_restart: word_out=%h valid=%b, expected 01/1", word_out, word_valid);
      end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      checks++;
      if (word_parity !== 1'b1) begin
         errors++;
         $display("FAIL parity_01: got %b expected 1", word_parity);
      end
`endif
      word_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      word_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bit_valid = 1'b1;
         bit_in    = i[0];
         tick();
      end
      bit_valid = 1'b0;
      checks++;
      if (word_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_valid: valid=%b expected 1", word_valid);
      end
      #2;
      areset = 1'b1;
      #1;
      checks++;
      if (word_out !== '0 || word_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: word_out=%h valid=%b ovf=%b, expected 00/0/0", word_out, word_valid, overflow);
      end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
      checks++;
      if (word_parity !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_parity: got %b expected 0", word_parity);
      end
`endif
      tick();
      areset = 1'b0;
      m_reset();
      word_ready = 1'b1;
      send_word(8'hA5);
      bit_valid = 1'b0;
      checks++;
      if (word_out !== 8'hA5 || word_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_word: word_out=%h valid=%b, expected a5/1", word_out, word_valid);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         frame_start  = ($urandom_range(0, 15) == 0);
         bit_valid    = ($urandom_range(0, 3) != 0);
         bit_in       = 1'($urandom);
         word_ready   = 1'($urandom);
         clr_overflow = ($urandom_range(0, 7) == 0);
         tick();
         checks++;
         if (word_valid !== m_valid || word_out !== m_word || overflow !== m_ovf) begin
            errors++;
            $display("FAIL random[%0d]: word_out=%h valid=%b ovf=%b, expected %h/%b/%b",
                     n, word_out, word_valid, overflow, m_word, m_valid, m_ovf);
         end
`ifdef SERIAL_WORD_COLLECTOR_PARITY_EN
         checks++;
         if (word_parity !== m_par) begin
            errors++;
            $display("FAIL random_parity[%0d]: got %b expected %b", n, word_parity, m_par);
         end
`endif
      end
      frame_start  = 1'b0;
      bit_valid    = 1'b0;
      clr_overflow = 1'b0;
   endtask

   initial begin
      m_reset();
      #1;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_simultaneous();
      test_frame_restart();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
